commit_trace_capture: RTL and testbench

//  Hardware capture of the multicycle core's retirement trace: on each commit pulse it stores the {PC, WriteBackData} pair.

---
 rtl/commit_trace_capture_pkg.sv | 31 +++
 rtl/commit_trace_capture_if.sv | 29 ++
 rtl/commit_trace_capture_fifo.sv | 76 +++++++
 rtl/commit_trace_capture.sv | 158 +++++++++++++++
 tb/tb_commit_trace_capture.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_capture_pkg.sv
// Shared types and constants for the commit trace capture block:
// trace entry layout, drain FSM state encoding and entry field helpers.
package commit_trace_capture_pkg;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int DROP_W  = 16;
    localparam int TRACE_W = 64;

    // One retired instruction: PC in the upper word, WriteBackData in the lower word.
    typedef logic [TRACE_W-1:0] trace_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BEAT_PC = 2'd1,
        ST_BEAT_WB = 2'd2
    } state_t;

    function automatic logic [31:0] trPc(input trace_t entry);
        return entry[63:32];
    endfunction

    function automatic logic [31:0] trWb(input trace_t entry);
        return entry[31:0];
    endfunction

    function automatic trace_t packEntry(input logic [31:0] pc, input logic [31:0] wb);
        return {pc, wb};
    endfunction

endpackage

// File: rtl/commit_trace_capture_if.sv
// Commit-side inputs, drain stream and status signals of the trace capture block.
// The slave modport is the capture block; the master modport is the core/consumer side.
interface commit_trace_capture_if #(
    parameter int ADDR_W = commit_trace_capture_pkg::ADDR_W,
    parameter int DROP_W = commit_trace_capture_pkg::DROP_W
);
    logic              clear;
    logic              commit;
    logic [31:0]       pc;
    logic [31:0]       wb_data;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output clear, commit, pc, wb_data, out_ready,
        input  out_data, out_valid, out_last, count, overflow, drop_cnt
    );

    modport slave (
        input  clear, commit, pc, wb_data, out_ready,
        output out_data, out_valid, out_last, count, overflow, drop_cnt
    );

endinterface

// File: rtl/commit_trace_capture_fifo.sv
// trace_fifo: DEPTH x 64-bit register FIFO holding retired {PC, WB} pairs.
// A push while full is accepted when a pop happens in the same cycle.
// Exposes both the head entry and the one behind it so the drain FSM can
// present the next PC beat directly after a pop without a bubble.
module trace_fifo #(
    parameter int DEPTH  = commit_trace_capture_pkg::DEPTH,
    parameter int ADDR_W = commit_trace_capture_pkg::ADDR_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_clear,
    input  logic                            i_push,
    input  logic                            i_pop,
    input  commit_trace_capture_pkg::trace_t i_wdata,
    output commit_trace_capture_pkg::trace_t o_head,
    output commit_trace_capture_pkg::trace_t o_second,
    output logic [ADDR_W:0]                 o_count,
    output logic                            o_full,
    output logic                            o_empty
);
    import commit_trace_capture_pkg::*;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    trace_t            r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_rdNext;

    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);
    assign w_pop    = i_pop && !o_empty && !i_clear;
    assign w_push   = i_push && (!o_full || w_pop) && !i_clear;
    assign w_rdNext = r_rdPtr + PTR_ONE;
    assign o_head   = r_mem[r_rdPtr];
    assign o_second = r_mem[w_rdNext];
    assign o_count  = r_count;

    // Storage array carries no reset; count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; clear flushes everything back to empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdNext;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_capture.sv
// commit_trace_capture: buffers {PC, WriteBackData} on every commit pulse and
// drains each entry as two 32-bit stream beats (PC, then WB with out_last).
// Commits that arrive while the buffer is full are dropped and counted.
module commit_trace_capture #(
    parameter int DEPTH  = commit_trace_capture_pkg::DEPTH,
    parameter int ADDR_W = commit_trace_capture_pkg::ADDR_W,
    parameter int DROP_W = commit_trace_capture_pkg::DROP_W
) (
    input logic                    clk,
    input logic                    rst,
    commit_trace_capture_if.slave  bus
);
    import commit_trace_capture_pkg::*;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_outValid;
    logic              w_nextValid;
    logic              r_outLast;
    logic              w_nextLast;
    logic [31:0]       r_outData;
    logic [31:0]       w_nextData;
    logic              r_overflow;
    logic [DROP_W-1:0] r_dropCnt;

    trace_t            w_head;
    trace_t            w_second;
    trace_t            w_incoming;
    trace_t            w_afterPop;
    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    assign w_incoming = packEntry(bus.pc, bus.wb_data);
    assign w_pop      = r_outValid && r_outLast && bus.out_ready && !bus.clear;
    assign w_push     = bus.commit && !bus.clear && (!w_full || w_pop);
    assign w_drop     = bus.commit && !bus.clear && w_full && !w_pop;
    assign w_afterPop = (w_count > CNT_ONE) ? w_second : w_incoming;

    trace_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (bus.clear),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wdata  (w_incoming),
        .o_head   (w_head),
        .o_second (w_second),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Drain FSM next-state and next-output logic; clear abandons any beat in flight.
    always_comb begin
        w_nextState = r_state;
        w_nextValid = r_outValid;
        w_nextLast  = r_outLast;
        w_nextData  = r_outData;
        if (bus.clear) begin
            w_nextState = ST_IDLE;
            w_nextValid = 1'b0;
            w_nextLast  = 1'b0;
            w_nextData  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nextValid = 1'b0;
                    w_nextLast  = 1'b0;
                    if (!w_empty) begin
                        w_nextState = ST_BEAT_PC;
                        w_nextValid = 1'b1;
                        w_nextData  = trPc(w_head);
                    end else if (w_push) begin
                        w_nextState = ST_BEAT_PC;
                        w_nextValid = 1'b1;
                        w_nextData  = trPc(w_incoming);
                    end
                end
                ST_BEAT_PC: begin
                    if (bus.out_ready) begin
                        w_nextState = ST_BEAT_WB;
                        w_nextLast  = 1'b1;
                        w_nextData  = trWb(w_head);
                    end
                end
                ST_BEAT_WB: begin
                    if (bus.out_ready) begin
                        if ((w_count > CNT_ONE) || w_push) begin
                            w_nextState = ST_BEAT_PC;
                            w_nextValid = 1'b1;
                            w_nextLast  = 1'b0;
                            w_nextData  = trPc(w_afterPop);
                        end else begin
                            w_nextState = ST_IDLE;
                            w_nextValid = 1'b0;
                            w_nextLast  = 1'b0;
                        end
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                    w_nextValid = 1'b0;
                    w_nextLast  = 1'b0;
                    w_nextData  = '0;
                end
            endcase
        end
    end

    // Registered drain FSM state and stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_outValid <= w_nextValid;
            r_outLast  <= w_nextLast;
            r_outData  <= w_nextData;
        end
    end

    // Sticky overflow flag and saturating count of commits lost to a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCnt != '1) begin
                r_dropCnt <= r_dropCnt + DROP_ONE;
            end
        end
    end

    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;
    assign bus.out_last  = r_outLast;
    assign bus.count     = w_count;
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_dropCnt;

endmodule

// File: tb/tb_commit_trace_capture.sv
// Directed testbench for commit_trace_capture: single entry latency,
// backpressure, overflow, full push+pop, clear, async reset and pointer wrap.
module tb_commit_trace_capture;
    import commit_trace_capture_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    commit_trace_capture_if #(.ADDR_W(4), .DROP_W(16)) bus ();

    commit_trace_capture #(
        .DEPTH  (16),
        .ADDR_W (4),
        .DROP_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit in case the design stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] time limit");
    end

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of commit inputs, then advance past the edge.
    task automatic applyStimulus(input logic commit, input logic [31:0] pc, input logic [31:0] wb);
        bus.commit  = commit;
        bus.pc      = pc;
        bus.wb_data = wb;
        tick();
        bus.commit  = 1'b0;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the stream state in one call.
    task automatic checkBeat(input string tag, input logic valid, input logic last, input logic [31:0] data);
        checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'(valid));
        checkOutput({tag, "_last"},  64'(bus.out_last),  64'(last));
        checkOutput({tag, "_data"},  64'(bus.out_data),  64'(data));
    endtask

    // Directed sequence.
    initial begin
        int beat;
        int pushed;
        logic [31:0] expData;

        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.commit    = 1'b0;
        bus.pc        = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkBeat("rst", 1'b0, 1'b0, 32'h0);
        checkOutput("rst_count", 64'(bus.count), 64'd0);
        checkOutput("rst_ovf",   64'(bus.overflow), 64'd0);
        checkOutput("rst_drop",  64'(bus.drop_cnt), 64'd0);

        $display("[TB] single entry");
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_0004, 32'h0000_0005);
        checkBeat("t1_pc", 1'b1, 1'b0, 32'h0000_0004);
        checkOutput("t1_count1", 64'(bus.count), 64'd1);
        tick();
        checkBeat("t1_wb", 1'b1, 1'b1, 32'h0000_0005);
        tick();
        checkOutput("t1_idle_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t1_idle_count", 64'(bus.count), 64'd0);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i));
        end
        repeat (10) tick();
        checkOutput("t2_count", 64'(bus.count), 64'd3);
        checkBeat("t2_hold", 1'b1, 1'b0, 32'h100);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expData = (i % 2 == 0) ? 32'h100 + 32'(i / 2) : 32'h200 + 32'(i / 2);
            checkBeat("t2_beat", 1'b1, 1'(i % 2), expData);
            tick();
        end
        checkOutput("t2_end_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] overflow");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'(4 * i), 32'h7000 + 32'(i));
        end
        checkOutput("t3_count", 64'(bus.count), 64'd16);
        checkOutput("t3_ovf",   64'(bus.overflow), 64'd1);
        checkOutput("t3_drop",  64'(bus.drop_cnt), 64'd4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checkBeat("t3_pc", 1'b1, 1'b0, 32'(4 * i));
            tick();
            checkBeat("t3_wb", 1'b1, 1'b1, 32'h7000 + 32'(i));
            tick();
        end
        checkOutput("t3_end_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t3_end_count", 64'(bus.count), 64'd0);
        checkOutput("t3_ovf_sticky", 64'(bus.overflow), 64'd1);

        $display("[TB] full push+pop");
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checkOutput("t4_clr_ovf",  64'(bus.overflow), 64'd0);
        checkOutput("t4_clr_drop", 64'(bus.drop_cnt), 64'd0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
        end
        checkOutput("t4_full", 64'(bus.count), 64'd16);
        bus.out_ready = 1'b1;
        tick();
        checkBeat("t4_wb0", 1'b1, 1'b1, 32'h2000);
        applyStimulus(1'b1, 32'h1010, 32'h2010);
        checkOutput("t4_count", 64'(bus.count), 64'd16);
        checkOutput("t4_drop",  64'(bus.drop_cnt), 64'd0);
        checkOutput("t4_ovf",   64'(bus.overflow), 64'd0);
        for (int i = 1; i <= 16; i++) begin
            checkBeat("t4_pc", 1'b1, 1'b0, 32'h1000 + 32'(i));
            tick();
            checkBeat("t4_wb", 1'b1, 1'b1, 32'h2000 + 32'(i));
            tick();
        end
        checkOutput("t4_end_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] clear mid-stream");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 32'h3000 + 32'(i), 32'h3100 + 32'(i));
        end
        checkOutput("t5_pre_drop", 64'(bus.drop_cnt), 64'd1);
        checkOutput("t5_pre_ovf",  64'(bus.overflow), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        checkBeat("t5_wb", 1'b1, 1'b1, 32'h3100);
        bus.clear = 1'b1;
        applyStimulus(1'b1, 32'hDEAD_0000, 32'hBEEF_0000);
        bus.clear = 1'b0;
        checkOutput("t5_count", 64'(bus.count), 64'd0);
        checkOutput("t5_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t5_ovf",   64'(bus.overflow), 64'd0);
        checkOutput("t5_drop",  64'(bus.drop_cnt), 64'd0);
        tick();
        checkOutput("t5_after_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t5_after_count", 64'(bus.count), 64'd0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 32'h4000, 32'h4001);
        checkBeat("t6_pc", 1'b1, 1'b0, 32'h4000);
        #2;
        rst = 1'b1;
        #1;
        checkBeat("t6_rst", 1'b0, 1'b0, 32'h0);
        checkOutput("t6_rst_count", 64'(bus.count), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        checkOutput("t6_post_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] pointer wrap");
        beat   = 0;
        pushed = 0;
        for (int c = 0; c < 120 && beat < 80; c++) begin
            if (bus.out_valid) begin
                expData = (beat % 2 == 0) ? 32'h5000 + 32'(beat / 2) : 32'h6000 + 32'(beat / 2);
                checkOutput("wrap_data", 64'(bus.out_data), 64'(expData));
                checkOutput("wrap_last", 64'(bus.out_last), 64'(beat % 2));
                beat++;
            end
            if ((c % 2 == 0) && (pushed < 40)) begin
                bus.commit  = 1'b1;
                bus.pc      = 32'h5000 + 32'(pushed);
                bus.wb_data = 32'h6000 + 32'(pushed);
                pushed++;
            end else begin
                bus.commit = 1'b0;
            end
            tick();
        end
        bus.commit = 1'b0;
        checkOutput("wrap_beats", 64'(beat), 64'd80);
        checkOutput("wrap_drop",  64'(bus.drop_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
